// File: rtl/writeback_stage.sv
// MEM/WB pipeline register: picks the writeback source, extracts big-endian load data,
// and registers the register-file write port, a sticky misaligned-load flag and a retire counter.
module writeback_stage #(
    parameter int COUNT_WIDTH = 32,
    parameter bit ZERO_GUARD  = 1'b1
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   stall,
    input  logic                   flush,
    input  logic                   in_valid,
    input  logic                   in_reg_write,
    input  logic [4:0]             in_write_address,
    input  logic [1:0]             in_result_src,
    input  logic [31:0]            in_alu_result,
    input  logic [31:0]            in_mem_data,
    input  logic [31:0]            in_link_pc,
    input  logic [2:0]             in_load_type,
    output logic                   write_enable,
    output logic [4:0]             write_address,
    output logic [31:0]            write_data,
    output logic                   align_error,
    output logic [31:0]            error_pc_addr,
    output logic [COUNT_WIDTH-1:0] retired_count
);

    logic [1:0]  offset;
    logic [7:0]  load_byte;
    logic [15:0] load_half;
    logic [31:0] load_value;
    logic [31:0] selected_result;
    logic        misaligned;
    logic        zero_hit;
    logic        write_enable_next;

    assign offset = in_alu_result[1:0];

    always_comb begin
        load_byte         = 8'h00;
        load_half         = 16'h0000;
        load_value        = in_mem_data;
        selected_result   = in_alu_result;
        misaligned        = 1'b0;
        zero_hit          = 1'b0;
        write_enable_next = 1'b0;

        // Big-endian lanes: offset 0 is the most significant byte/half.
        case (offset)
            2'd0:    load_byte = in_mem_data[31:24];
            2'd1:    load_byte = in_mem_data[23:16];
            2'd2:    load_byte = in_mem_data[15:8];
            default: load_byte = in_mem_data[7:0];
        endcase
        load_half = offset[1] ? in_mem_data[15:0] : in_mem_data[31:16];

        case (in_load_type)
            3'd1:    load_value = {{24{load_byte[7]}}, load_byte};
            3'd2:    load_value = {24'h000000, load_byte};
            3'd3:    load_value = {{16{load_half[15]}}, load_half};
            3'd4:    load_value = {16'h0000, load_half};
            default: load_value = in_mem_data;
        endcase

        if (in_valid && in_result_src == 2'd1) begin
            case (in_load_type)
                3'd1, 3'd2: misaligned = 1'b0;
                3'd3, 3'd4: misaligned = offset[0];
                default:    misaligned = (offset != 2'd0);
            endcase
        end

        case (in_result_src)
            2'd1:    selected_result = load_value;
            2'd2:    selected_result = in_link_pc;
            default: selected_result = in_alu_result;
        endcase

        zero_hit          = ZERO_GUARD && (in_write_address == 5'd0);
        write_enable_next = in_valid && in_reg_write && !misaligned && !zero_hit;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            write_enable  <= 1'b0;
            write_address <= 5'd0;
            write_data    <= 32'd0;
            align_error   <= 1'b0;
            error_pc_addr <= 32'd0;
            retired_count <= '0;
        end else if (flush) begin
            write_enable  <= 1'b0;
            write_address <= 5'd0;
            write_data    <= 32'd0;
        end else if (!stall) begin
            write_enable <= write_enable_next;
            if (in_valid) begin
                write_address <= in_write_address;
                write_data    <= selected_result;
                retired_count <= retired_count + COUNT_WIDTH'(1);
            end else begin
                write_address <= 5'd0;
                write_data    <= 32'd0;
            end
            // Only the first misaligned load's address is kept for debug.
            if (misaligned && !align_error) begin
                align_error   <= 1'b1;
                error_pc_addr <= in_alu_result;
            end
        end
    end

endmodule

// File: tb/tb_writeback_stage.sv
// Self-checking bench for writeback_stage: directed scenarios plus randomized traffic
// checked against an arithmetic reference model of the stage.
module tb_writeback_stage;

    logic        clock = 1'b0;
    logic        reset;
    logic        stall;
    logic        flush;
    logic        in_valid;
    logic        in_reg_write;
    logic [4:0]  in_write_address;
    logic [1:0]  in_result_src;
    logic [31:0] in_alu_result;
    logic [31:0] in_mem_data;
    logic [31:0] in_link_pc;
    logic [2:0]  in_load_type;
    logic        write_enable;
    logic [4:0]  write_address;
    logic [31:0] write_data;
    logic        align_error;
    logic [31:0] error_pc_addr;
    logic [31:0] retired_count;

    int tests_run    = 0;
    int tests_failed = 0;

    logic        exp_we;
    logic [4:0]  exp_addr;
    logic [31:0] exp_data;
    logic        exp_err;
    logic [31:0] exp_epc;
    logic [31:0] exp_count;

    writeback_stage #(.COUNT_WIDTH(32), .ZERO_GUARD(1'b1)) dut (
        .clock(clock), .reset(reset), .stall(stall), .flush(flush),
        .in_valid(in_valid), .in_reg_write(in_reg_write),
        .in_write_address(in_write_address), .in_result_src(in_result_src),
        .in_alu_result(in_alu_result), .in_mem_data(in_mem_data),
        .in_link_pc(in_link_pc), .in_load_type(in_load_type),
        .write_enable(write_enable), .write_address(write_address),
        .write_data(write_data), .align_error(align_error),
        .error_pc_addr(error_pc_addr), .retired_count(retired_count)
    );

    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [102:0] obs_bundle();
        return {write_enable, write_address, write_data, align_error, error_pc_addr, retired_count};
    endfunction

    function automatic logic [102:0] exp_bundle();
        return {exp_we, exp_addr, exp_data, exp_err, exp_epc, exp_count};
    endfunction

    task automatic model_reset();
        exp_we = 0; exp_addr = 0; exp_data = 0; exp_err = 0; exp_epc = 0; exp_count = 0;
    endtask

    // Reference behaviour from the stage rules, evaluated on the inputs present at the edge.
    task automatic model_step();
        int unsigned off, lt, b, h, value;
        bit mis;
        if (flush) begin
            exp_we = 0; exp_addr = 0; exp_data = 0;
        end else if (stall) begin
            // everything holds
        end else if (!in_valid) begin
            exp_we = 0; exp_addr = 0; exp_data = 0;
        end else begin
            off = in_alu_result % 4;
            lt  = (in_load_type > 4) ? 0 : in_load_type;
            b   = (in_mem_data >> (8 * (3 - off))) & 32'hFF;
            h   = (in_mem_data >> (16 * (1 - off / 2))) & 32'hFFFF;
            case (lt)
                1: value = (b >= 128) ? b - 256 : b;
                2: value = b;
                3: value = (h >= 32768) ? h - 65536 : h;
                4: value = h;
                default: value = in_mem_data;
            endcase
            mis = 0;
            if (in_result_src == 1) begin
                if ((lt == 3 || lt == 4) && (off % 2 == 1)) mis = 1;
                if (lt == 0 && off != 0) mis = 1;
            end
            if (in_result_src == 1)      exp_data = value;
            else if (in_result_src == 2) exp_data = in_link_pc;
            else                         exp_data = in_alu_result;
            exp_addr  = in_write_address;
            exp_we    = in_reg_write && !mis && (in_write_address != 0);
            exp_count = exp_count + 1;
            if (mis && !exp_err) begin
                exp_err = 1;
                exp_epc = in_alu_result;
            end
        end
    endtask

    task automatic drive(input logic v, input logic rw, input logic [4:0] a, input logic [1:0] src,
                         input logic [31:0] alu, input logic [31:0] mem, input logic [31:0] link,
                         input logic [2:0] lt);
        in_valid = v; in_reg_write = rw; in_write_address = a; in_result_src = src;
        in_alu_result = alu; in_mem_data = mem; in_link_pc = link; in_load_type = lt;
    endtask

    task automatic step();
        model_step();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1; stall = 0; flush = 0;
        drive(1, 1, 5'd3, 2'd0, 32'hDEADBEEF, 32'h0, 32'h0, 3'd0);
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        tests_run++;
        if (obs_bundle() !== 103'd0) begin
            tests_failed++;
            $display("FAIL reset_state: got %h required %h", obs_bundle(), 103'd0);
        end
        @(negedge clock);
        reset = 0;
        drive(0, 0, 5'd0, 2'd0, 32'h0, 32'h0, 32'h0, 3'd0);
        step();
        tests_run++;
        if (obs_bundle() !== 103'd0) begin
            tests_failed++;
            $display("FAIL idle_bubble: got %h required %h", obs_bundle(), 103'd0);
        end
    endtask

    task automatic test_alu();
        drive(1, 1, 5'd8, 2'd0, 32'h12345678, 32'hAAAA5555, 32'h0, 3'd0);
        step();
        tests_run++;
        if ({write_enable, write_address, write_data, retired_count} !== {1'b1, 5'd8, 32'h12345678, 32'd1}) begin
            tests_failed++;
            $display("FAIL alu_writeback: got we=%b a=%0d d=%h cnt=%0d required we=1 a=8 d=12345678 cnt=1",
                     write_enable, write_address, write_data, retired_count);
        end
    endtask

    task automatic test_load_extract();
        logic [31:0] addrs [5];
        logic [2:0]  types [5];
        logic [31:0] wants [5];
        addrs = '{32'h100, 32'h101, 32'h102, 32'h100, 32'h100};
        types = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd0};
        wants = '{32'hFFFFFF80, 32'h000000F1, 32'h00007F02, 32'h000080F1, 32'h80F17F02};
        for (int i = 0; i < 5; i++) begin
            drive(1, 1, 5'd9, 2'd1, addrs[i], 32'h80F17F02, 32'h0, types[i]);
            step();
            tests_run++;
            if (write_data !== wants[i] || write_enable !== 1'b1) begin
                tests_failed++;
                $display("FAIL load_extract[%0d]: got we=%b d=%h required we=1 d=%h",
                         i, write_enable, write_data, wants[i]);
            end
        end
    endtask

    task automatic test_misalign();
        logic [31:0] cnt0;
        cnt0 = exp_count;
        drive(1, 1, 5'd10, 2'd1, 32'h00000106, 32'h11223344, 32'h0, 3'd0);
        step();
        tests_run++;
        if ({write_enable, align_error, error_pc_addr} !== {1'b0, 1'b1, 32'h106}) begin
            tests_failed++;
            $display("FAIL misalign_lw: got we=%b err=%b epc=%h required we=0 err=1 epc=00000106",
                     write_enable, align_error, error_pc_addr);
        end
        drive(1, 1, 5'd11, 2'd1, 32'h00000201, 32'h11223344, 32'h0, 3'd3);
        step();
        tests_run++;
        if ({write_enable, align_error, error_pc_addr, retired_count} !== {1'b0, 1'b1, 32'h106, cnt0 + 32'd2}) begin
            tests_failed++;
            $display("FAIL misalign_sticky: got we=%b err=%b epc=%h cnt=%0d required we=0 err=1 epc=00000106 cnt=%0d",
                     write_enable, align_error, error_pc_addr, retired_count, cnt0 + 2);
        end
    endtask

    task automatic test_zero_link();
        drive(1, 1, 5'd0, 2'd2, 32'h0, 32'h0, 32'h00400008, 3'd0);
        step();
        tests_run++;
        if (write_enable !== 1'b0) begin
            tests_failed++;
            $display("FAIL zero_guard: got we=%b required we=0", write_enable);
        end
        drive(1, 1, 5'd31, 2'd2, 32'h5, 32'h0, 32'h00400008, 3'd0);
        step();
        tests_run++;
        if ({write_enable, write_address, write_data} !== {1'b1, 5'd31, 32'h00400008}) begin
            tests_failed++;
            $display("FAIL link_write: got we=%b a=%0d d=%h required we=1 a=31 d=00400008",
                     write_enable, write_address, write_data);
        end
    endtask

    task automatic test_stall_flush();
        logic [102:0] held;
        held = obs_bundle();
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, 5'(i + 4), 2'd0, $urandom, $urandom, $urandom, 3'd0);
            step();
            tests_run++;
            if (obs_bundle() !== held) begin
                tests_failed++;
                $display("FAIL stall_hold[%0d]: got %h required %h", i, obs_bundle(), held);
            end
        end
        flush = 1;
        drive(1, 1, 5'd7, 2'd0, 32'hCAFEF00D, 32'h0, 32'h0, 3'd0);
        step();
        tests_run++;
        if ({write_enable, write_address, write_data, retired_count} !== {1'b0, 5'd0, 32'd0, held[31:0]}) begin
            tests_failed++;
            $display("FAIL stall_flush: got we=%b a=%0d d=%h cnt=%0d required we=0 a=0 d=0 cnt=%0d",
                     write_enable, write_address, write_data, retired_count, held[31:0]);
        end
        stall = 0; flush = 0;
        drive(1, 1, 5'd12, 2'd3, 32'h0BADC0DE, 32'h0, 32'h0, 3'd0);
        step();
        tests_run++;
        if ({write_enable, write_address, write_data, retired_count} !== {1'b1, 5'd12, 32'h0BADC0DE, held[31:0] + 32'd1}) begin
            tests_failed++;
            $display("FAIL release_capture: got we=%b a=%0d d=%h cnt=%0d required we=1 a=12 d=0badc0de cnt=%0d",
                     write_enable, write_address, write_data, retired_count, held[31:0] + 1);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            stall = ($urandom_range(0, 7) == 0);
            flush = ($urandom_range(0, 7) == 0);
            drive($urandom_range(0, 5) != 0, $urandom_range(0, 3) != 0,
                  ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom),
                  2'($urandom), $urandom, $urandom, $urandom, 3'($urandom));
            step();
            tests_run++;
            if (obs_bundle() !== exp_bundle()) begin
                tests_failed++;
                $display("FAIL random[%0d]: got %h required %h", i, obs_bundle(), exp_bundle());
            end
        end
        stall = 0; flush = 0;
    endtask

    task automatic test_async_reset();
        drive(1, 1, 5'd20, 2'd0, 32'h13579BDF, 32'h0, 32'h0, 3'd0);
        step();
        tests_run++;
        if (write_enable !== 1'b1) begin
            tests_failed++;
            $display("FAIL pre_reset_write: got we=%b required we=1", write_enable);
        end
        #2;
        reset = 1;
        #1;
        tests_run++;
        if (obs_bundle() !== 103'd0) begin
            tests_failed++;
            $display("FAIL async_reset: got %h required %h", obs_bundle(), 103'd0);
        end
        stall = 1; flush = 1;
        @(posedge clock);
        #1;
        tests_run++;
        if (obs_bundle() !== 103'd0) begin
            tests_failed++;
            $display("FAIL reset_held: got %h required %h", obs_bundle(), 103'd0);
        end
        #2;
        reset = 0; stall = 0; flush = 0;
        model_reset();
        drive(1, 0, 5'd6, 2'd0, 32'h2468ACE0, 32'h0, 32'h0, 3'd0);
        step();
        tests_run++;
        if ({write_enable, write_address, write_data, retired_count} !== {1'b0, 5'd6, 32'h2468ACE0, 32'd1}) begin
            tests_failed++;
            $display("FAIL post_reset_capture: got we=%b a=%0d d=%h cnt=%0d required we=0 a=6 d=2468ace0 cnt=1",
                     write_enable, write_address, write_data, retired_count);
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_load_extract();
        test_misalign();
        test_zero_link();
        test_stall_flush();
        test_random();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
